// File: rtl/stall_mgmt.sv
// Global stall manager: merges buffer-full and sink back-pressure into a registered stall/flush broadcast.
// Optional watchdog flush is compiled in only when STALL_MGMT_TIMEOUT_EN is defined.
module stall_mgmt #(
  parameter int NUM_BUF        = 4,
  parameter int RESUME_DELAY   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BUF-1:0] buf_full,
  input  logic               sink_ready,
  input  logic               flush_req,
  output logic               stall,
  output logic               flush,
  output logic [1:0]         state,
  output logic [15:0]        stall_cycles,
  output logic               timeout
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_RESUME = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  if (NUM_BUF < 1 || RESUME_DELAY < 0 || RESUME_DELAY > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_err
    $error("stall_mgmt: parameter out of range");
  end

  state_e      state_q, state_d;
  logic [3:0]  resume_q, resume_d;
  logic        stall_q, flush_q;
  logic [15:0] cycles_q;
  logic        cause;
  logic        wd_fire;

  assign cause = (|buf_full) | ~sink_ready;

`ifdef STALL_MGMT_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        timeout_q;
  logic        in_stall;

  // wd_q holds how many consecutive STALL/RESUME cycles preceded the current one
  always_comb begin
    in_stall = (state_q == ST_STALL) || (state_q == ST_RESUME);
    wd_fire  = in_stall && (wd_q == 16'(TIMEOUT_CYCLES - 1));
    wd_d     = in_stall ? wd_q + 16'd1 : 16'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q      <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    if (state_q == ST_FLUSH) begin
      state_d = ST_RUN;
    end else if (flush_req || wd_fire) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cause) state_d = ST_STALL;
        end
        ST_STALL: begin
          if (!cause) begin
            if (RESUME_DELAY == 0) begin
              state_d = ST_RUN;
            end else begin
              state_d  = ST_RESUME;
              resume_d = 4'(RESUME_DELAY);
            end
          end
        end
        ST_RESUME: begin
          if (cause) begin
            state_d = ST_STALL;
          end else if (resume_q <= 4'd1) begin
            state_d = ST_RUN;
          end else begin
            resume_d = resume_q - 4'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Outputs are registered alongside the state so they come straight from flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      resume_q <= 4'd0;
      stall_q  <= 1'b0;
      flush_q  <= 1'b0;
      cycles_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      stall_q  <= (state_d != ST_RUN);
      flush_q  <= (state_d == ST_FLUSH);
      if (stall_q && (cycles_q != 16'hFFFF)) cycles_q <= cycles_q + 16'd1;
    end
  end

  assign stall        = stall_q;
  assign flush        = flush_q;
  assign state        = state_q;
  assign stall_cycles = cycles_q;

endmodule

// File: tb/tb_stall_mgmt.sv
// Scoreboard bench for stall_mgmt: the driver queues expected outputs per target cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_stall_mgmt;

  localparam logic [1:0] RUN = 2'd0, STL = 2'd1, RES = 2'd2, FLS = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  buf_full = 4'd0;
  logic        sink_ready = 1'b1;
  logic        flush_req = 1'b0;
  logic        stall, flush, timeout;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  stall_mgmt #(.NUM_BUF(4), .RESUME_DELAY(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .buf_full(buf_full), .sink_ready(sink_ready),
    .flush_req(flush_req), .stall(stall), .flush(flush), .state(state),
    .stall_cycles(stall_cycles), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tgt;
    string       name;
    logic [1:0]  st;
    logic        stl;
    logic        fl;
    logic        to;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic step(input logic [3:0] bf, input logic sr, input logic fr, input logic rst);
    @(posedge clk);
    #1;
    buf_full = bf; sink_ready = sr; flush_req = fr; reset = rst;
  endtask

  // Expected outputs after the next rising edge (inputs just driven by step)
  task automatic expect_out(input string name, input logic [1:0] st, input logic stl,
                            input logic fl, input logic to, input logic [15:0] cyc);
    exp_t e;
    e.tgt = cyc_cnt + 1; e.name = name; e.st = st; e.stl = stl; e.fl = fl; e.to = to; e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].tgt <= cyc_cnt) begin
      e = sb_q.pop_front();
      total++;
      if (e.tgt < cyc_cnt) begin
        bad++;
        $display("FAIL %s: sample slot %0d missed (now %0d)", e.name, e.tgt, cyc_cnt);
      end else if (state !== e.st || stall !== e.stl || flush !== e.fl ||
                   timeout !== e.to || stall_cycles !== e.cyc) begin
        bad++;
        $display("FAIL %s: got state=%0d stall=%b flush=%b timeout=%b cycles=%0d, want state=%0d stall=%b flush=%b timeout=%b cycles=%0d",
                 e.name, state, stall, flush, timeout, stall_cycles,
                 e.st, e.stl, e.fl, e.to, e.cyc);
      end else begin
        $display("ok   %s: state=%0d stall=%b flush=%b timeout=%b cycles=%0d",
                 e.name, state, stall, flush, timeout, stall_cycles);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL time_limit: simulation still running, %0d checks pending", sb_q.size());
    $fatal(1, "time limit");
  end

  task automatic do_reset(input string name);
    step(4'h0, 1'b1, 1'b0, 1'b0);
    expect_out(name, RUN, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    step(4'h0, 1'b1, 1'b0, 1'b0);
    do_reset("reset_state");

    // Basic stall: one buffer full for three cycles
    step(4'h2, 1'b1, 1'b0, 1'b1); expect_out("basic_stall1", STL, 1, 0, 0, 16'd0);
    step(4'h2, 1'b1, 1'b0, 1'b1); expect_out("basic_stall2", STL, 1, 0, 0, 16'd1);
    step(4'h2, 1'b1, 1'b0, 1'b1); expect_out("basic_stall3", STL, 1, 0, 0, 16'd2);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("basic_resume1", RES, 1, 0, 0, 16'd3);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("basic_resume2", RES, 1, 0, 0, 16'd4);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("basic_run", RUN, 0, 0, 0, 16'd5);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("basic_hold", RUN, 0, 0, 0, 16'd5);

    // Re-stall on the first RESUME cycle, then full delay repeated
    do_reset("reset_restall");
    step(4'h1, 1'b1, 1'b0, 1'b1); expect_out("restall_stall", STL, 1, 0, 0, 16'd0);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("restall_resume", RES, 1, 0, 0, 16'd1);
    step(4'h0, 1'b0, 1'b0, 1'b1); expect_out("restall_back", STL, 1, 0, 0, 16'd2);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("restall_res1", RES, 1, 0, 0, 16'd3);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("restall_res2", RES, 1, 0, 0, 16'd4);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("restall_run", RUN, 0, 0, 0, 16'd5);

    // Flush beats every buffer full; all-ones plus sink not ready is a plain cause
    do_reset("reset_flush");
    step(4'hF, 1'b1, 1'b1, 1'b1); expect_out("flush_enter", FLS, 1, 1, 0, 16'd0);
    step(4'hF, 1'b1, 1'b0, 1'b1); expect_out("flush_run", RUN, 0, 0, 0, 16'd1);
    step(4'hF, 1'b0, 1'b0, 1'b1); expect_out("flush_stall", STL, 1, 0, 0, 16'd1);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("flush_resume", RES, 1, 0, 0, 16'd2);

    // Held flush_req alternates FLUSH and RUN
    do_reset("reset_hold");
    step(4'h0, 1'b1, 1'b1, 1'b1); expect_out("hold_flush1", FLS, 1, 1, 0, 16'd0);
    step(4'h0, 1'b1, 1'b1, 1'b1); expect_out("hold_run1", RUN, 0, 0, 0, 16'd1);
    step(4'h0, 1'b1, 1'b1, 1'b1); expect_out("hold_flush2", FLS, 1, 1, 0, 16'd1);
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("hold_run2", RUN, 0, 0, 0, 16'd2);

    // Reset wins over a simultaneous flush request
    step(4'hF, 1'b0, 1'b1, 1'b0); expect_out("reset_over_flush", RUN, 0, 0, 0, 16'd0);

    // Sink held not-ready: watchdog flush when compiled in, endless stall otherwise
    for (int i = 1; i <= 11; i++) begin
      step(4'h0, 1'b0, 1'b0, 1'b1);
`ifdef STALL_MGMT_TIMEOUT_EN
      if (i <= 8)       expect_out($sformatf("wd_%0d", i), STL, 1, 0, 0, 16'(i - 1));
      else if (i == 9)  expect_out("wd_flush", FLS, 1, 1, 1, 16'd8);
      else if (i == 10) expect_out("wd_run", RUN, 0, 0, 1, 16'd9);
      else              expect_out("wd_restall", STL, 1, 0, 1, 16'd9);
`else
      expect_out($sformatf("wd_%0d", i), STL, 1, 0, 0, 16'(i - 1));
`endif
    end
    do_reset("reset_after_wd");

`ifndef STALL_MGMT_TIMEOUT_EN
    // Reset mid-RESUME with 37 counted stall cycles
    for (int i = 1; i <= 37; i++) begin
      step(4'h1, 1'b1, 1'b0, 1'b1);
      if (i == 37) expect_out("mid_stall37", STL, 1, 0, 0, 16'd36);
    end
    step(4'h0, 1'b1, 1'b0, 1'b1); expect_out("mid_resume", RES, 1, 0, 0, 16'd37);
    step(4'h0, 1'b1, 1'b0, 1'b0); expect_out("mid_reset", RUN, 0, 0, 0, 16'd0);

    // Saturation of the stall counter
    for (int i = 1; i <= 65600; i++) begin
      step(4'h1, 1'b1, 1'b0, 1'b1);
      if (i == 65535) expect_out("sat_fffe", STL, 1, 0, 0, 16'hFFFE);
      if (i == 65536) expect_out("sat_ffff", STL, 1, 0, 0, 16'hFFFF);
      if (i == 65600) expect_out("sat_hold", STL, 1, 0, 0, 16'hFFFF);
    end
    do_reset("reset_after_sat");
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
